// File: rtl/dac_sample_feeder_pkg.sv
// Shared types and constants for the DAC sample feeder.
package dac_feeder_pkg;

    localparam int DW_DEFAULT     = 24;
    localparam int UNDERRUN_CNT_W = 16;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/dac_sample_feeder_fifo.sv
// Synchronous FIFO holding packed stereo samples; head entry is read combinationally.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Stereo sample buffer feeding the codec DAC words once per LRCK frame.
// Optional FEEDER_MUTE_ON_UNDERRUN_EN: zero the words on underrun and on PRIME frames.
module dac_sample_feeder
    import dac_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = DW_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DW-1:0]             s_left,
    input  logic [DW-1:0]             s_right,
    input  logic                      lrck,
    output logic [DW-1:0]             LCH_DAC,
    output logic [DW-1:0]             RCH_DAC,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      running,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);
    localparam int LW = $clog2(DEPTH) + 1;
`ifdef FEEDER_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    feeder_state_t state, next_state;
    logic          lrck_d;
    logic          fs;
    logic          full;
    logic          empty;
    logic          pop;
    logic          mute;
    logic          ur_hit;
    logic          prime_ok;
    logic [2*DW-1:0] head;

    // lrck_d tracks lrck even in reset so a high lrck at release is not an edge.
    always_ff @(posedge clk) lrck_d <= lrck;

    assign fs       = lrck && !lrck_d;
    assign s_ready  = !rst && !full;
    assign prime_ok = (level >= LW'(DEPTH / 2));
    assign running  = (state == RUN);

    sample_fifo #(.DEPTH(DEPTH), .W(2 * DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid && s_ready),
        .pop   (pop),
        .din   ({s_left, s_right}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= PRIME;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            PRIME:   if (fs && prime_ok) next_state = RUN;
            RUN:     if (fs && empty)    next_state = PRIME;
            default: next_state = PRIME;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        mute   = 1'b0;
        ur_hit = 1'b0;
        case (state)
            PRIME: begin
                if (fs) begin
                    pop  = prime_ok;
                    mute = MUTE_EN && !prime_ok;
                end
            end
            RUN: begin
                if (fs) begin
                    pop    = !empty;
                    ur_hit = empty;
                    mute   = MUTE_EN && empty;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LCH_DAC <= '0;
            RCH_DAC <= '0;
        end else if (pop) begin
            {LCH_DAC, RCH_DAC} <= head;
        end else if (mute) begin
            LCH_DAC <= '0;
            RCH_DAC <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) underrun <= 1'b0;
        else     underrun <= ur_hit;
    end

    always_ff @(posedge clk) begin
        if (rst)                             underrun_cnt <= '0;
        else if (ur_hit && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench: frame stimulus queues expected DAC words, a monitor checks them after each LRCK rise.
module tb_dac_sample_feeder;
    localparam int DEPTH = 8;
    localparam int DW    = 24;
    localparam int LW    = 4;
`ifdef FEEDER_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_left = '0;
    logic [DW-1:0] s_right = '0;
    logic          lrck = 1'b1;
    logic [DW-1:0] LCH_DAC;
    logic [DW-1:0] RCH_DAC;
    logic [LW-1:0] level;
    logic          running;
    logic          underrun;
    logic [15:0]   underrun_cnt;

    dac_sample_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .lrck         (lrck),
        .LCH_DAC      (LCH_DAC),
        .RCH_DAC      (RCH_DAC),
        .level        (level),
        .running      (running),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          ur;
        logic          run;
    } frame_t;

    frame_t exp_q[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] neg(input logic [DW-1:0] v);
        return -v;
    endfunction

    // Monitor: on every frame strobe pop one expectation; otherwise words must hold and underrun stay low.
    logic          lrck_q = 1'b1;
    logic [DW-1:0] last_l = '0;
    logic [DW-1:0] last_r = '0;
    always @(posedge clk) begin
        logic   fs_s;
        logic   rst_s;
        frame_t e;
        fs_s   = lrck && !lrck_q;
        lrck_q = lrck;
        rst_s  = rst;
        #1;
        if (!rst_s) begin
            if (fs_s) begin
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_frame: got frame want none");
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_l",   32'(LCH_DAC),  32'(e.l));
                    chk("frame_r",   32'(RCH_DAC),  32'(e.r));
                    chk("frame_ur",  32'(underrun), 32'(e.ur));
                    chk("frame_run", 32'(running),  32'(e.run));
                end
            end else begin
                chk("hold", 32'(LCH_DAC == last_l && RCH_DAC == last_r && !underrun), 32'd1);
            end
        end
        last_l = LCH_DAC;
        last_r = RCH_DAC;
    end

    task automatic push(input logic [DW-1:0] v);
        @(negedge clk);
        chk("push_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_left  = v;
        s_right = neg(v);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic frame(input bit do_push, input logic [DW-1:0] pv,
                         input logic [DW-1:0] el, input bit eur, input bit erun);
        frame_t e;
        e.l = el; e.r = neg(el); e.ur = eur; e.run = erun;
        @(negedge clk);
        exp_q.push_back(e);
        lrck = 1'b1;
        if (do_push) begin
            s_valid = 1'b1;
            s_left  = pv;
            s_right = neg(pv);
        end
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        lrck = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] v;
        repeat (4) @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready",   32'(s_ready),      32'd1);
        chk("rel_level",   32'(level),        32'd0);
        chk("rel_running", 32'(running),      32'd0);
        chk("rel_l",       32'(LCH_DAC),      32'd0);
        chk("rel_r",       32'(RCH_DAC),      32'd0);
        chk("rel_cnt",     32'(underrun_cnt), 32'd0);
        lrck = 1'b0;
        repeat (2) @(negedge clk);

        // Prefill below threshold: frames must not pop
        for (int k = 1; k <= 3; k++) push(DW'(k));
        chk("prime_level3", 32'(level), 32'd3);
        frame(0, '0, '0, 0, 0);
        frame(0, '0, '0, 0, 0);
        chk("prime_hold_level", 32'(level), 32'd3);
        push(DW'(4));
        frame(0, '0, DW'(1), 0, 1);
        chk("run_level", 32'(level), 32'd3);

        // Fill to full; held s_valid must not be accepted
        for (int k = 5; k <= 9; k++) push(DW'(k));
        chk("full_level", 32'(level),   32'd8);
        chk("full_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        s_valid = 1'b1; s_left = DW'(10); s_right = neg(DW'(10));
        repeat (3) @(negedge clk);
        chk("full_hold_level", 32'(level), 32'd8);
        s_valid = 1'b0;
        frame(0, '0, DW'(2), 0, 1);
        chk("after_full_level", 32'(level),   32'd7);
        chk("after_full_ready", 32'(s_ready), 32'd1);

        for (int k = 3; k <= 7; k++) frame(0, '0, DW'(k), 0, 1);
        chk("drain_level2", 32'(level), 32'd2);
        frame(1, DW'(10), DW'(8), 0, 1);
        chk("push_pop_level", 32'(level), 32'd2);
        frame(0, '0, DW'(9), 0, 1);
        frame(0, '0, DW'(10), 0, 1);
        chk("empty_level", 32'(level), 32'd0);
        frame(0, '0, MUTE ? '0 : DW'(10), 1, 0);
        chk("ur_cnt1",   32'(underrun_cnt), 32'd1);
        chk("ur_prime",  32'(running),      32'd0);

        // Counter saturation; the last underrun frame also carries a push
        @(negedge clk);
        force dut.underrun_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.underrun_cnt;
        for (int it = 0; it < 3; it++) begin
            for (int j = 0; j < 4; j++) push(DW'(32'h100 + it * 4 + j));
            for (int j = 0; j < 4; j++) frame(0, '0, DW'(32'h100 + it * 4 + j), 0, 1);
            v = DW'(32'h100 + it * 4 + 3);
            frame(it == 2, DW'(32'h200), MUTE ? '0 : v, 1, 0);
            chk("cnt_sat", 32'(underrun_cnt), 32'hFFFF);
        end
        chk("push_on_ur_level", 32'(level), 32'd1);
        frame(0, '0, MUTE ? '0 : DW'(32'h10B), 0, 0);

        // Reset mid-frame
        @(negedge clk);
        lrck = 1'b1;
        rst  = 1'b1;
        @(negedge clk);
        chk("mrst_l",       32'(LCH_DAC),      32'd0);
        chk("mrst_r",       32'(RCH_DAC),      32'd0);
        chk("mrst_level",   32'(level),        32'd0);
        chk("mrst_running", 32'(running),      32'd0);
        chk("mrst_ur",      32'(underrun),     32'd0);
        chk("mrst_cnt",     32'(underrun_cnt), 32'd0);
        chk("mrst_ready",   32'(s_ready),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mrel_ready", 32'(s_ready), 32'd1);
        chk("mrel_level", 32'(level),   32'd0);
        repeat (4) @(negedge clk);
        chk("frames_pending", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
